frame_tx: RTL and testbench



---
 rtl/frame_pkg.sv | 50 +++++
 rtl/frame_tx_buf.sv | 49 ++++
 rtl/frame_tx.sv | 162 ++++++++++++++++
 tb/tb_frame_tx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the framed 16-bit link (transmitter and detector).
// Contents: frame delimiter words, buffer geometry, transmitter state
// encoding, captured-command payload and the CRC-16 (0x1021) step function.
package frame_pkg;

    localparam logic [15:0] HEADER_W  = 16'hE0E0;
    localparam logic [15:0] TRAILER_W = 16'h0E0E;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PTR_W  = 3;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned LEN_W  = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_HDR_H,
        S_HDR_L,
        S_CHAN,
        S_DATA,
        S_CRC,
        S_TRL_H,
        S_TRL_L,
        S_GAP
    } tx_state_t;

    // Command fields captured on the command handshake.
    typedef struct packed {
        logic [CH_W-1:0]  channel;
        logic [LEN_W-1:0] len;
        logic             crc_inv;
    } tx_cmd_t;

    // CRC-16/0x1021, MSB first, 16 data bits folded per call.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_tx_buf.sv
// Payload buffer for frame_tx: 8 x 16-bit, written in acceptance order and
// read back in the same order.
// Ports:
//   clk_in, rst_n      clock, synchronous active-low reset
//   clr                rewinds both pointers for a new command
//   wr_en, wr_data     store one payload word
//   rd_en              advance the read pointer
//   rd_data_c          word at the read pointer (combinational)
module frame_tx_buf
    import frame_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data_c
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointer and storage update.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/frame_tx.sv
// Framed-link transmitter: accepts a command and its payload words, then
// sends header, channel, payload, CRC and trailer as one contiguous burst.
// Ports:
//   clk_in, rst_n                          clock, synchronous active-low reset
//   cmd_valid/cmd_ready                    command handshake
//   cmd_channel, cmd_len, cmd_crc_inv      one-hot channel, words-1, CRC invert
//   pld_valid/pld_ready, pld_data          payload word handshake
//   data_out, data_out_vld                 line word and frame-word qualifier
//   busy                                   not idle
//   frame_done                             pulse in the cycle after the trailer
//   err_cmd                                pulse after a rejected command
module frame_tx
    import frame_pkg::*;
#(
    parameter logic [15:0] IDLE_WORD = 16'h0000,
    parameter int unsigned MIN_GAP   = 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_channel,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_crc_inv,
    input  logic              pld_valid,
    output logic              pld_ready,
    input  logic [WORD_W-1:0] pld_data,
    output logic [WORD_W-1:0] data_out,
    output logic              data_out_vld,
    output logic              busy,
    output logic              frame_done,
    output logic              err_cmd
);

    localparam int unsigned GAP_W = 4;

    tx_state_t          state;
    tx_state_t          state_next;
    tx_cmd_t            cmd_q;
    logic [WORD_W-1:0]  crc_q;
    logic [LEN_W-1:0]   wcnt;
    logic [LEN_W-1:0]   dcnt;
    logic [GAP_W-1:0]   gcnt;

    logic               cmd_fire;
    logic               pld_fire;
    logic               cmd_ok;
    logic               rd_en;
    logic [WORD_W-1:0]  rd_data;
    logic [WORD_W-1:0]  data_next;
    logic               vld_next;

    frame_tx_buf u_buf (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .clr       (cmd_fire),
        .wr_en     (pld_fire),
        .wr_data   (pld_data),
        .rd_en     (rd_en),
        .rd_data_c (rd_data)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the line word for the coming cycle; data_out is
    // registered from the next state so the header lands one cycle after
    // the last payload accept.
    always_comb begin
        cmd_fire   = cmd_valid && cmd_ready;
        pld_fire   = pld_valid && pld_ready;
        cmd_ok     = $onehot(cmd_channel);
        state_next = state;
        data_next  = IDLE_WORD;
        vld_next   = 1'b0;
        rd_en      = 1'b0;

        case (state)
            S_IDLE:  if (cmd_fire && cmd_ok) state_next = S_LOAD;
            S_LOAD:  if (pld_fire && (wcnt == cmd_q.len)) state_next = S_HDR_H;
            S_HDR_H: state_next = S_HDR_L;
            S_HDR_L: state_next = S_CHAN;
            S_CHAN:  state_next = S_DATA;
            S_DATA:  if (dcnt == cmd_q.len) state_next = S_CRC;
            S_CRC:   state_next = S_TRL_H;
            S_TRL_H: state_next = S_TRL_L;
            S_TRL_L: state_next = S_GAP;
            S_GAP:   if (gcnt == GAP_W'(MIN_GAP - 1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_HDR_H, S_HDR_L: begin
                data_next = HEADER_W;
                vld_next  = 1'b1;
            end
            S_CHAN: begin
                data_next = {8'h00, cmd_q.channel};
                vld_next  = 1'b1;
            end
            S_DATA: begin
                data_next = rd_data;
                vld_next  = 1'b1;
                rd_en     = 1'b1;
            end
            S_CRC: begin
                data_next = crc_q ^ {16{cmd_q.crc_inv}};
                vld_next  = 1'b1;
            end
            S_TRL_H, S_TRL_L: begin
                data_next = TRAILER_W;
                vld_next  = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs, command capture, CRC and counters.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            data_out     <= IDLE_WORD;
            data_out_vld <= 1'b0;
            cmd_ready    <= 1'b0;
            pld_ready    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err_cmd      <= 1'b0;
            cmd_q        <= '0;
            crc_q        <= '0;
            wcnt         <= '0;
            dcnt         <= '0;
            gcnt         <= '0;
        end else begin
            data_out     <= data_next;
            data_out_vld <= vld_next;
            cmd_ready    <= (state_next == S_IDLE);
            pld_ready    <= (state_next == S_LOAD);
            busy         <= (state_next != S_IDLE);
            frame_done   <= (state == S_TRL_L);
            err_cmd      <= cmd_fire && !cmd_ok;

            if (cmd_fire) begin
                cmd_q <= '{channel: cmd_channel, len: cmd_len, crc_inv: cmd_crc_inv};
                crc_q <= '0;
                wcnt  <= '0;
            end else if (pld_fire) begin
                crc_q <= crc16_step(crc_q, pld_data);
                wcnt  <= wcnt + LEN_W'(1);
            end

            dcnt <= (state == S_DATA) ? dcnt + LEN_W'(1) : '0;
            gcnt <= (state == S_GAP)  ? gcnt + GAP_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: stimulus pushes expected line words and
// frame lengths; an independent monitor checks every cycle of data_out.
module tb_frame_tx;

    localparam logic [15:0] IDLE_WORD = 16'h0000;
    localparam int unsigned MIN_GAP   = 1;
    localparam logic [15:0] HDR       = 16'hE0E0;
    localparam logic [15:0] TRL       = 16'h0E0E;

    logic        clk_in;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_channel;
    logic [2:0]  cmd_len;
    logic        cmd_crc_inv;
    logic        pld_valid;
    logic        pld_ready;
    logic [15:0] pld_data;
    logic [15:0] data_out;
    logic        data_out_vld;
    logic        busy;
    logic        frame_done;
    logic        err_cmd;

    frame_tx #(.IDLE_WORD(IDLE_WORD), .MIN_GAP(MIN_GAP)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_channel  (cmd_channel),
        .cmd_len      (cmd_len),
        .cmd_crc_inv  (cmd_crc_inv),
        .pld_valid    (pld_valid),
        .pld_ready    (pld_ready),
        .pld_data     (pld_data),
        .data_out     (data_out),
        .data_out_vld (data_out_vld),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_cmd      (err_cmd)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    int          len_q[$];
    bit          abort_exp = 0;
    int          err_exp = 0;
    int          err_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CRC: remainder of (message * x^16) mod 0x11021 by long division.
    function automatic logic [15:0] model_crc(input logic [15:0] w[8], input int n);
        bit          b[144];
        int          nb;
        logic [16:0] poly;
        logic [15:0] r;
        poly = 17'h11021;
        nb   = 16 * n + 16;
        for (int k = 0; k < 144; k++) b[k] = 1'b0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 16; j++) b[16 * i + j] = w[i][15 - j];
        for (int i = 0; i + 16 < nb; i++)
            if (b[i])
                for (int j = 0; j < 17; j++) b[i + j] = b[i + j] ^ poly[16 - j];
        for (int j = 0; j < 16; j++) r[15 - j] = b[nb - 16 + j];
        return r;
    endfunction

    // Monitor: compares every line cycle against the scoreboard.
    initial begin
        int run      = 0;
        int idle_run = 0;
        bit prev_vld = 0;
        bit first    = 1;
        @(posedge clk_in);
        forever begin
            @(negedge clk_in);
            if (err_cmd === 1'b1) err_seen++;
            if (data_out_vld === 1'b1) begin
                if (!prev_vld) begin
                    if (!first) check("gap_len_ok", 32'(idle_run >= int'(MIN_GAP) + 1), 32'd1);
                    first = 0;
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %h expected no frame word at %0t", data_out, $time);
                end else begin
                    check("frame_word", 32'(data_out), 32'(exp_q.pop_front()));
                end
                run++;
                idle_run = 0;
            end else begin
                check("idle_word", 32'(data_out), 32'(IDLE_WORD));
                if (prev_vld) begin
                    int exp_len;
                    exp_len = (len_q.size() > 0) ? len_q.pop_front() : -1;
                    if (abort_exp) begin
                        check("abort_no_done", 32'(frame_done), 32'd0);
                        check("abort_short", 32'(run < exp_len), 32'd1);
                        for (int k = run; k < exp_len; k++)
                            if (exp_q.size() > 0) void'(exp_q.pop_front());
                        abort_exp = 0;
                        first     = 1;
                    end else begin
                        check("frame_len", 32'(run), 32'(exp_len));
                        check("frame_done", 32'(frame_done), 32'd1);
                    end
                    run = 0;
                end else begin
                    check("no_done", 32'(frame_done), 32'd0);
                end
                idle_run++;
            end
            prev_vld = (data_out_vld === 1'b1);
        end
    end

    task automatic send_frame(input logic [7:0] ch, input int len, input logic [15:0] w[8],
                              input bit inv, input int skip_pct, input bit alt,
                              input bit force_crc, input logic [15:0] crc_lit);
        logic [15:0] crc;
        bit          rdy;
        int          i;
        int          guard;
        crc = force_crc ? crc_lit : (model_crc(w, len + 1) ^ {16{inv}});
        exp_q.push_back(HDR);
        exp_q.push_back(HDR);
        exp_q.push_back({8'h00, ch});
        for (int k = 0; k <= len; k++) exp_q.push_back(w[k]);
        exp_q.push_back(crc);
        exp_q.push_back(TRL);
        exp_q.push_back(TRL);
        len_q.push_back(len + 7);

        cmd_valid = 1'b1; cmd_channel = ch; cmd_len = 3'(len); cmd_crc_inv = inv;
        guard = 0;
        forever begin
            rdy = cmd_ready;
            @(posedge clk_in); #1;
            if (rdy) break;
            guard++;
            if (guard > 300) begin
                check("cmd_timeout", 32'd1, 32'd0);
                break;
            end
        end
        cmd_valid = 1'b0;

        i = 0; guard = 0;
        while (i <= len && guard < 500) begin
            pld_valid = alt ? 1'(guard % 2) : ($urandom_range(99) >= 32'(skip_pct));
            pld_data  = w[i];
            rdy       = pld_ready && pld_valid;
            @(posedge clk_in); #1;
            guard++;
            if (rdy) begin
                i++;
                if (i > len) begin
                    check("hdr_latency", {15'd0, data_out_vld, data_out}, {15'd0, 1'b1, HDR});
                    check("pld_ready_drop", 32'(pld_ready), 32'd0);
                end
            end
        end
        pld_valid = 1'b0;
        if (i <= len) check("pld_timeout", 32'(i), 32'(len + 1));
    endtask

    task automatic bad_cmd(input logic [7:0] ch);
        bit rdy;
        int guard;
        cmd_valid = 1'b1; cmd_channel = ch; cmd_len = 3'($urandom_range(7)); cmd_crc_inv = 1'b0;
        guard = 0;
        forever begin
            rdy = cmd_ready;
            @(posedge clk_in); #1;
            if (rdy) break;
            guard++;
            if (guard > 300) begin
                check("bad_cmd_timeout", 32'd1, 32'd0);
                break;
            end
        end
        cmd_valid = 1'b0;
        err_exp++;
        check("err_cmd_pulse", 32'(err_cmd), 32'd1);
        check("err_pld_ready", 32'(pld_ready), 32'd0);
        check("err_cmd_ready", 32'(cmd_ready), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        @(posedge clk_in); #1;
        check("err_cmd_clear", 32'(err_cmd), 32'd0);
        check("err_vld_low", 32'(data_out_vld), 32'd0);
    endtask

    initial begin
        logic [15:0] w [8];
        int          guard;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_channel = '0; cmd_len = '0;
        cmd_crc_inv = 1'b0; pld_valid = 1'b0; pld_data = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_data_out", 32'(data_out), 32'(IDLE_WORD));
        check("rst_vld", 32'(data_out_vld), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pld_ready", 32'(pld_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", {30'd0, frame_done, err_cmd}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk_in); #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Known-answer single word.
        w = '{16'hA55A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send_frame(8'h01, 0, w, 1'b0, 0, 1'b0, 1'b1, 16'h1934);

        // Eight words with pld_valid toggling.
        w = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
        send_frame(8'h02, 7, w, 1'b0, 0, 1'b1, 1'b0, 16'h0);

        // Inverted CRC.
        w = '{16'hA55A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send_frame(8'h01, 0, w, 1'b1, 0, 1'b0, 1'b1, 16'hE6CB);

        // Leading zero words leave the CRC unchanged.
        w = '{16'h0000, 16'h0000, 16'hA55A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send_frame(8'h40, 2, w, 1'b0, 0, 1'b0, 1'b1, 16'h1934);

        // Rejected channels.
        bad_cmd(8'h03);
        bad_cmd(8'h00);

        // Reset while sending payload.
        w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        send_frame(8'h04, 7, w, 1'b0, 0, 1'b0, 1'b0, 16'h0);
        repeat (4) @(posedge clk_in);
        #1;
        abort_exp = 1;
        rst_n = 1'b0;
        @(posedge clk_in); #1;
        check("abort_idle_word", 32'(data_out), 32'(IDLE_WORD));
        check("abort_vld", 32'(data_out_vld), 32'd0);
        rst_n = 1'b1;
        w = '{16'hE0E0, 16'h0E0E, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send_frame(8'h08, 2, w, 1'b0, 0, 1'b0, 1'b0, 16'h0);

        // Back-to-back commands.
        w = '{16'hCAFE, 16'hF00D, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send_frame(8'h10, 1, w, 1'b0, 0, 1'b0, 1'b0, 16'h0);
        w = '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send_frame(8'h80, 0, w, 1'b0, 0, 1'b0, 1'b0, 16'h0);

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            int len;
            len = int'($urandom_range(7));
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(9))
                    0: w[k] = HDR;
                    1: w[k] = TRL;
                    2: w[k] = 16'h0000;
                    default: w[k] = 16'($urandom);
                endcase
            end
            send_frame(8'(1 << $urandom_range(7)), len, w, 1'($urandom_range(1)),
                       int'($urandom_range(60)), 1'b0, 1'b0, 16'h0);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(posedge clk_in);
            guard++;
        end
        repeat (6) @(posedge clk_in);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("err_cmd_count", 32'(err_seen), 32'(err_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
